// File: rtl/transmitter_pkg.sv
// Shared definitions for the UART transmit control path: FSM state encoding
// and the counter-width helper used by the baud and bit counters.
package transmitter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } state_t;

  // A counter over 0..n-1 needs at least one bit, even when n is 1.
  function automatic int unsigned count_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/transmitter_baud_counter.sv
// Baud divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit period.
module transmitter_baud_counter
  import transmitter_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_equal
);

  localparam int unsigned Width = count_width(CLKS_PER_BIT);
  localparam logic [Width-1:0] LastCount = Width'(CLKS_PER_BIT - 1);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable) begin
      count_d = (count_q == LastCount) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_equal = (count_q == LastCount);

endmodule

// File: rtl/transmitter_control.sv
// UART transmit sequencer: accepts a byte, holds it for the frame and walks
// START/DATA/STOP, owning all bit timing for the downstream shifter.
module transmitter_control
  import transmitter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_value,
  output logic                  o_state_is_START,
  output logic                  o_state_is_DATA,
  output logic                  o_equal,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned BitWidth = $clog2(DATA_WIDTH + 1);
  localparam logic [BitWidth-1:0] LastData = BitWidth'(DATA_WIDTH - 1);
  localparam logic [BitWidth-1:0] LastStop = BitWidth'(STOP_BITS - 1);

  state_t                state_q, state_d;
  logic [BitWidth-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic                  baud_equal;
  logic                  idle;

  assign idle = (state_q == StIdle);

  // Every state exit coincides with a baud wrap, so clearing in IDLE is
  // enough to start each state at count 0.
  transmitter_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (idle),
    .i_enable(!idle),
    .o_equal (baud_equal)
  );

  assign o_equal = !idle && baud_equal;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    value_d   = value_q;
    case (state_q)
      StIdle: begin
        if (i_valid) begin
          state_d   = StStart;
          bit_cnt_d = '0;
          value_d   = i_data;
        end
      end
      StStart: begin
        if (o_equal) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (o_equal) begin
          if (bit_cnt_q == LastData) begin
            state_d   = StStop;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (o_equal) begin
          if (bit_cnt_q == LastStop) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d   = StIdle;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      value_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      value_q   <= value_d;
    end
  end

  assign o_ready          = idle;
  assign o_busy           = !idle;
  assign o_value          = value_q;
  assign o_state_is_START = (state_q == StStart);
  assign o_state_is_DATA  = (state_q == StData);
  assign o_done           = (state_q == StStop) && o_equal && (bit_cnt_q == LastStop);

endmodule

// File: tb/tb_transmitter_control.sv
// Directed bench for transmitter_control: three parameterisations share the
// stimulus, and the one under test is selected for observation.
module tb_transmitter_control;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data  = 8'h00;
  logic [1:0] sel   = 2'd0;

  logic       ready_w[3];
  logic       start_w[3];
  logic       dat_w[3];
  logic       equal_w[3];
  logic       busy_w[3];
  logic       done_w[3];
  logic [7:0] value_w[3];

  logic       ready_o, start_o, dat_o, equal_o, busy_o, done_o;
  logic [7:0] value_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instance 0: CLKS_PER_BIT=4, STOP_BITS=1
  transmitter_control #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1)
  ) u_base (
    .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_data(data),
    .o_ready(ready_w[0]), .o_value(value_w[0]), .o_state_is_START(start_w[0]),
    .o_state_is_DATA(dat_w[0]), .o_equal(equal_w[0]), .o_busy(busy_w[0]),
    .o_done(done_w[0])
  );

  // Instance 1: CLKS_PER_BIT=4, STOP_BITS=2
  transmitter_control #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(2)
  ) u_stop2 (
    .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_data(data),
    .o_ready(ready_w[1]), .o_value(value_w[1]), .o_state_is_START(start_w[1]),
    .o_state_is_DATA(dat_w[1]), .o_equal(equal_w[1]), .o_busy(busy_w[1]),
    .o_done(done_w[1])
  );

  // Instance 2: CLKS_PER_BIT=1, STOP_BITS=1
  transmitter_control #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(1), .STOP_BITS(1)
  ) u_fast (
    .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_data(data),
    .o_ready(ready_w[2]), .o_value(value_w[2]), .o_state_is_START(start_w[2]),
    .o_state_is_DATA(dat_w[2]), .o_equal(equal_w[2]), .o_busy(busy_w[2]),
    .o_done(done_w[2])
  );

  always_comb begin
    ready_o = ready_w[sel];
    start_o = start_w[sel];
    dat_o   = dat_w[sel];
    equal_o = equal_w[sel];
    busy_o  = busy_w[sel];
    done_o  = done_w[sel];
    value_o = value_w[sel];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string where);
    check({where, "_ready"}, 32'(ready_o), 32'd1);
    check({where, "_busy"},  32'(busy_o),  32'd0);
    check({where, "_start"}, 32'(start_o), 32'd0);
    check({where, "_data"},  32'(dat_o),   32'd0);
    check({where, "_equal"}, 32'(equal_o), 32'd0);
    check({where, "_done"},  32'(done_o),  32'd0);
    check({where, "_value"}, 32'(value_o), 32'd0);
  endtask

  // Reset is asserted for one edge and released #1 after it, leaving the DUT idle.
  task automatic do_reset();
    rst   = 1'b1;
    valid = 1'b0;
    data  = 8'h00;
    #1;
    check_reset_values("reset");
    tick();
    rst = 1'b0;
  endtask

  // Called in cycle 0 with valid/data already driven; returns in cycle len+1 (IDLE).
  task automatic run_frame(input int cpb, input int sb, input logic [7:0] val,
                           input logic hold, input logic [7:0] next);
    int len;
    int pulses;
    len    = (1 + 8 + sb) * cpb;
    pulses = 0;
    check("accept_ready", 32'(ready_o), 32'd1);
    tick();
    valid = hold;
    data  = next;
    for (int c = 1; c <= len + 1; c++) begin
      check($sformatf("start@%0d", c), 32'(start_o), 32'(c <= cpb));
      check($sformatf("data@%0d", c),  32'(dat_o),   32'(c > cpb && c <= 9 * cpb));
      check($sformatf("busy@%0d", c),  32'(busy_o),  32'(c <= len));
      check($sformatf("ready@%0d", c), 32'(ready_o), 32'(c == len + 1));
      check($sformatf("done@%0d", c),  32'(done_o),  32'(c == len));
      check($sformatf("equal@%0d", c), 32'(equal_o), 32'(c <= len && (c % cpb) == 0));
      check($sformatf("value@%0d", c), 32'(value_o), 32'(val));
      if (equal_o) pulses++;
      if (c <= len) tick();
    end
    check("equal_pulses", 32'(pulses), 32'(9 + sb));
  endtask

  initial begin
    // Single frame, CLKS_PER_BIT=4
    sel = 2'd0;
    do_reset();
    valid = 1'b1;
    data  = 8'hA5;
    run_frame(4, 1, 8'hA5, 1'b0, 8'h00);

    // Valid held while busy: 0x3C must wait until cycle 41, START at 42
    do_reset();
    valid = 1'b1;
    data  = 8'hA5;
    run_frame(4, 1, 8'hA5, 1'b1, 8'h3C);
    run_frame(4, 1, 8'h3C, 1'b0, 8'h00);

    // Back-to-back 0x55 then 0xAA with valid held throughout
    do_reset();
    valid = 1'b1;
    data  = 8'h55;
    run_frame(4, 1, 8'h55, 1'b1, 8'hAA);
    run_frame(4, 1, 8'hAA, 1'b0, 8'h00);

    // Reset mid-DATA at cycle 20, then a clean 0x0F frame
    do_reset();
    valid = 1'b1;
    data  = 8'hC3;
    tick();
    valid = 1'b0;
    repeat (19) tick();
    check("mid_data_state", 32'(dat_o), 32'd1);
    check("mid_data_value", 32'(value_o), 32'hC3);
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    tick();
    rst   = 1'b0;
    valid = 1'b1;
    data  = 8'h0F;
    run_frame(4, 1, 8'h0F, 1'b0, 8'h00);

    // STOP_BITS=2: 44-cycle frame, 11 o_equal pulses
    sel = 2'd1;
    do_reset();
    valid = 1'b1;
    data  = 8'h96;
    run_frame(4, 2, 8'h96, 1'b0, 8'h00);

    // CLKS_PER_BIT=1: one cycle per bit, o_equal on every busy cycle
    sel = 2'd2;
    do_reset();
    valid = 1'b1;
    data  = 8'hFF;
    run_frame(1, 1, 8'hFF, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
